// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-extension multiply op encodings
// and multiplier FSM states.
package cpu_pkg;

   typedef logic [1:0] mul_op_t;

   localparam mul_op_t MUL_OP_MUL    = 2'd0;
   localparam mul_op_t MUL_OP_MULH   = 2'd1;
   localparam mul_op_t MUL_OP_MULHSU = 2'd2;
   localparam mul_op_t MUL_OP_MULHU  = 2'd3;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_RUN,
      MS_DONE
   } mul_state_t;

endpackage

// File: rtl/cpu_multiply_step.sv
// One shift-add iteration: adds mcand * slice, shifted into
// place, to the running 64-bit accumulator.
module cpu_multiply_step #(
   parameter int STEP_BITS = 1
) (
   input  logic [63:0]          acc_i,
   input  logic [31:0]          mcand_i,
   input  logic [STEP_BITS-1:0] slice_i,
   input  logic [5:0]           shift_i,
   output logic [63:0]          acc_o
);

   logic [63:0] pp;

   always_comb begin
      pp    = {32'd0, mcand_i} * {{(64-STEP_BITS){1'b0}}, slice_i};
      acc_o = acc_i + (pp << shift_i);
   end

endmodule

// File: rtl/cpu_multiply.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), STEP_BITS
// multiplier bits per cycle, one-cycle o_ready strobe.
module cpu_multiply
   import cpu_pkg::*;
#(
   parameter int STEP_BITS = 1
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_request,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   output logic        o_busy,
   output logic        o_ready,
   output logic [31:0] o_result
);

   localparam int N_STEPS = 32 / STEP_BITS;

   mul_state_t  state_q;
   mul_op_t     op_q;
   logic [31:0] mcand_q;
   logic [31:0] mplier_q;
   logic [63:0] acc_q;
   logic [63:0] acc_d;
   logic        neg_q;
   logic [5:0]  cnt_q;
   logic        busy_q;
   logic        ready_q;
   logic [31:0] result_q;

   logic        sgn1;
   logic        sgn2;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [5:0]  shift;
   logic        last;
   logic [63:0] prod;

   always_comb begin
      sgn1  = (i_op != MUL_OP_MULHU) & i_op1[31];
      sgn2  = ((i_op == MUL_OP_MUL) | (i_op == MUL_OP_MULH)) & i_op2[31];
      mag1  = sgn1 ? (~i_op1 + 32'd1) : i_op1;
      mag2  = sgn2 ? (~i_op2 + 32'd1) : i_op2;
      shift = cnt_q * 6'(STEP_BITS);
      last  = (cnt_q == 6'(N_STEPS - 1));
      prod  = neg_q ? (~acc_d + 64'd1) : acc_d;
   end

   cpu_multiply_step #(
      .STEP_BITS (STEP_BITS)
   ) u_step (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .slice_i (mplier_q[STEP_BITS-1:0]),
      .shift_i (shift),
      .acc_o   (acc_d)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= MS_IDLE;
         op_q     <= MUL_OP_MUL;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            MS_IDLE: begin
               if (i_request) begin
                  op_q     <= i_op;
                  mcand_q  <= mag1;
                  mplier_q <= mag2;
                  neg_q    <= sgn1 ^ sgn2;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= MS_RUN;
               end
            end
            MS_RUN: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_q >> STEP_BITS;
               cnt_q    <= cnt_q + 6'd1;
               // Sign fix and word select land with the last add,
               // so the DONE cycle presents the result.
               if (last) begin
                  result_q <= (op_q == MUL_OP_MUL) ? prod[31:0]
                                                   : prod[63:32];
                  ready_q  <= 1'b1;
                  state_q  <= MS_DONE;
               end
            end
            MS_DONE: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= MS_IDLE;
            end
            default: state_q <= MS_IDLE;
         endcase
      end
   end

   assign o_busy   = busy_q;
   assign o_ready  = ready_q;
   assign o_result = result_q;

endmodule

// File: tb/tb_cpu_multiply.sv
// Bench for cpu_multiply: directed cases on STEP_BITS=1 plus
// random ops across STEP_BITS 1,2,4,8 against a 66-bit model.
module tb_cpu_multiply;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  busy;
   logic [3:0]  rdy;
   logic [31:0] res [4];

   int checks = 0;
   int failures = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      cpu_multiply #(
         .STEP_BITS (1 << g)
      ) u_dut (
         .i_clock   (clk),
         .i_reset_n (rst_n),
         .i_request (req),
         .i_op      (op),
         .i_op1     (a),
         .i_op2     (b),
         .o_busy    (busy[g]),
         .o_ready   (rdy[g]),
         .o_result  (res[g])
      );
   end

   function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
      logic signed [32:0] sx;
      logic signed [32:0] sy;
      logic signed [65:0] p;
      sx = {(o != MUL_OP_MULHU) & x[31], x};
      sy = {(o == MUL_OP_MUL || o == MUL_OP_MULH) & y[31], y};
      p  = 66'(sx) * 66'(sy);
      return (o == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e);
      @(negedge clk);
      op = o; a = x; b = y; req = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b0;
   endtask

   // Waits on instance 0 (STEP_BITS=1); k counts cycles since request.
   task automatic wait0(input string tag, input int k0);
      int   k = k0;
      logic bok = 1'b1;
      logic [31:0] e;
      while (!rdy[0] && k < 100) begin
         bok &= busy[0];
         @(negedge clk);
         k++;
      end
      e = (sb.size() != 0) ? sb.pop_front() : 32'hx;
      chk({tag, "_rdy"}, rdy[0], 1);
      chk({tag, "_lat"}, k, 33);
      chk({tag, "_busy_run"}, {bok, busy[0]}, 2'b11);
      chk({tag, "_res"}, res[0], e);
      @(negedge clk);
      chk({tag, "_after"}, {rdy[0], busy[0]}, 2'b00);
   endtask

   initial begin
      logic        extra;
      logic [3:0]  seen;
      int          lat [4];
      int          nst [4];
      logic [31:0] got [4];
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;

      repeat (2) @(negedge clk);
      chk("reset_state", {busy[0], rdy[0], res[0]}, 34'h0);
      rst_n = 1'b1;

      issue(MUL_OP_MUL, 32'd7, 32'd6, 32'd42);
      wait0("mul7x6", 1);
      issue(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      wait0("mulh_min", 1);
      issue(MUL_OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0);
      wait0("mul_min", 1);
      issue(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait0("mulhsu_m1", 1);
      issue(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      wait0("mulhu_max", 1);
      repeat (3) @(negedge clk);
      chk("hold_idle", res[0], 32'hFFFF_FFFE);
      issue(MUL_OP_MULH, -32'sd3, 32'd5, 32'hFFFF_FFFF);
      wait0("mulh_n3x5", 1);

      issue(MUL_OP_MUL, -32'sd3, 32'd5, 32'hFFFF_FFF1);
      repeat (3) @(negedge clk);
      op = MUL_OP_MULHU; a = 32'h1234; b = 32'h5678; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait0("mul_n3x5_rereq", 5);
      extra = 1'b0;
      repeat (40) begin
         @(negedge clk);
         extra |= rdy[0];
      end
      chk("no_second_strobe", extra, 1'b0);

      issue(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_run", {busy[0], rdy[0], res[0]}, 34'h0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue(MUL_OP_MULHU, 32'h1234_5678, 32'h10, 32'h1);
      wait0("post_rst_mulhu", 1);

      for (int n = 0; n < 500; n++) begin
         ro = 2'($urandom_range(3));
         rx = pick();
         ry = pick();
         @(negedge clk);
         op = ro; a = rx; b = ry; req = 1'b1;
         sb.push_back(ref_mul(ro, rx, ry));
         @(negedge clk);
         req = 1'b0;
         seen = '0;
         for (int g = 0; g < 4; g++) begin
            lat[g] = 0; nst[g] = 0; got[g] = '0;
         end
         for (int k = 1; k <= 34; k++) begin
            for (int g = 0; g < 4; g++) begin
               if (rdy[g]) begin
                  nst[g]++;
                  if (!seen[g]) begin
                     seen[g] = 1'b1;
                     lat[g]  = k;
                     got[g]  = res[g];
                  end
               end
            end
            op = 2'($urandom); a = $urandom; b = $urandom;
            if (k < 34) @(negedge clk);
         end
         for (int g = 0; g < 4; g++) begin
            chk($sformatf("rnd%0d_s%0d_lat", n, 1 << g), lat[g],
                32 / (1 << g) + 1);
            chk($sformatf("rnd%0d_s%0d_nstrobe", n, 1 << g), nst[g], 1);
            chk($sformatf("rnd%0d_s%0d_res", n, 1 << g), got[g], sb[0]);
         end
         void'(sb.pop_front());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
